// File: rtl/contrast_pipe.sv
// Per-pixel contrast stage: scales R/G/B about MID by level/2^FRAC with clamping.
// Level stepped by inc/dec (edge + auto-repeat), committed at frame_start; 3-cycle pipeline.
module contrast_pipe #(
  parameter int DW         = 8,
  parameter int LW         = 4,
  parameter int FRAC       = 3,
  parameter int MID        = 128,
  parameter int PASS_W     = 24,
  parameter int REPEAT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_r,
  input  logic [DW-1:0]     in_g,
  input  logic [DW-1:0]     in_b,
  input  logic [PASS_W-1:0] pass_in,
  output logic              out_valid,
  output logic [DW-1:0]     out_r,
  output logic [DW-1:0]     out_g,
  output logic [DW-1:0]     out_b,
  output logic [PASS_W-1:0] pass_thru,
  output logic [LW-1:0]     level_out,
  output logic [LW-1:0]     level_pend
);

  localparam int PW = DW + LW;
  localparam int CW = (REPEAT_CYC > 2) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REPEAT_CYC - 1);
  localparam logic [LW-1:0] LVL_UNITY = LW'(1 << FRAC);
  localparam logic [LW-1:0] LVL_MAX   = '1;
  localparam logic [DW-1:0] MID_C     = DW'(MID);
  localparam logic signed [PW:0] MID_S = (PW+1)'(MID);
  localparam logic signed [PW:0] MAX_S = (PW+1)'((1 << DW) - 1);

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] c);
    return (c < MID_C) ? (MID_C - c) : (c - MID_C);
  endfunction

  // Truncating shift then clamp of MID +/- m into the channel range.
  function automatic logic [DW-1:0] scale_sat(input logic sgn, input logic [PW-1:0] prod);
    logic signed [PW:0] m;
    logic signed [PW:0] y;
    m = $signed({1'b0, prod >> FRAC});
    y = sgn ? (MID_S - m) : (MID_S + m);
    if (y < 0)          return '0;
    else if (y > MAX_S) return '1;
    else                return y[DW-1:0];
  endfunction

  // Level control
  logic          inc_prev_q, dec_prev_q;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic [LW-1:0] level_pend_q, level_pend_d;
  logic [LW-1:0] level_out_q, level_out_d;
  logic          inc_rise, dec_rise, rep_hit, step_up, step_dn;

  always_comb begin
    inc_rise     = inc & ~inc_prev_q;
    dec_rise     = dec & ~dec_prev_q;
    rep_hit      = (rep_cnt_q == CNT_LAST);
    step_up      = inc & ~dec & (inc_rise | rep_hit);
    step_dn      = dec & ~inc & (dec_rise | rep_hit);
    rep_cnt_d    = rep_cnt_q + 1'b1;
    level_pend_d = level_pend_q;
    level_out_d  = frame_start ? level_pend_q : level_out_q;
    if ((inc & dec) | ~(inc | dec) | inc_rise | dec_rise | rep_hit)
      rep_cnt_d = '0;
    if (step_up && level_pend_q != LVL_MAX)
      level_pend_d = level_pend_q + 1'b1;
    else if (step_dn && level_pend_q != '0)
      level_pend_d = level_pend_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_prev_q   <= 1'b0;
      dec_prev_q   <= 1'b0;
      rep_cnt_q    <= '0;
      level_pend_q <= LVL_UNITY;
      level_out_q  <= LVL_UNITY;
    end else begin
      inc_prev_q   <= inc;
      dec_prev_q   <= dec;
      rep_cnt_q    <= rep_cnt_d;
      level_pend_q <= level_pend_d;
      level_out_q  <= level_out_d;
    end
  end

  assign level_out  = level_out_q;
  assign level_pend = level_pend_q;

  // Pipeline storage; index 0/1/2 = r/g/b
  logic [2:0][DW-1:0]     chan_in;
  logic [2:0]             sign_p0_q, sign_p1_q;
  logic [2:0][DW-1:0]     mag_p0_q;
  logic [LW-1:0]          lvl_p0_q;
  logic [2:0][PW-1:0]     prod_p1_q;
  logic [2:0][DW-1:0]     pix_p2_q;
  logic                   vld_p0_q, vld_p1_q, vld_p2_q;
  logic [PASS_W-1:0]      pass_p0_q, pass_p1_q, pass_p2_q;

  assign chan_in = {in_b, in_g, in_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // S1: level select, sign and magnitude about MID
  always_ff @(posedge clk) begin
    lvl_p0_q  <= level_out_d;
    pass_p0_q <= pass_in;
    for (int i = 0; i < 3; i++) begin
      sign_p0_q[i] <= (chan_in[i] < MID_C);
      mag_p0_q[i]  <= abs_diff(chan_in[i]);
    end
  end

  // S2: unsigned gain multiply
  always_ff @(posedge clk) begin
    pass_p1_q <= pass_p0_q;
    sign_p1_q <= sign_p0_q;
    for (int i = 0; i < 3; i++)
      prod_p1_q[i] <= PW'(mag_p0_q[i]) * PW'(lvl_p0_q);
  end

  // S3: shift, re-centre, clamp
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_p2_q  <= '0;
      pass_p2_q <= '0;
    end else begin
      pass_p2_q <= pass_p1_q;
      for (int i = 0; i < 3; i++)
        pix_p2_q[i] <= scale_sat(sign_p1_q[i], prod_p1_q[i]);
    end
  end

  assign out_valid = vld_p2_q;
  assign out_r     = pix_p2_q[0];
  assign out_g     = pix_p2_q[1];
  assign out_b     = pix_p2_q[2];
  assign pass_thru = pass_p2_q;

endmodule

// File: tb/tb_contrast_pipe.sv
// Directed bench for contrast_pipe: level stepping/commit, pixel scaling, clamping, reset flush.
module tb_contrast_pipe;

  logic        clk = 1'b0;
  logic        rst, inc, dec, frame_start, in_valid;
  logic [7:0]  in_r, in_g, in_b;
  logic [23:0] pass_in;
  logic        out_valid;
  logic [7:0]  out_r, out_g, out_b;
  logic [23:0] pass_thru;
  logic [3:0]  level_out, level_pend;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  contrast_pipe #(
    .DW(8), .LW(4), .FRAC(3), .MID(128), .PASS_W(24), .REPEAT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .frame_start(frame_start),
    .in_valid(in_valid), .in_r(in_r), .in_g(in_g), .in_b(in_b), .pass_in(pass_in),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .pass_thru(pass_thru), .level_out(level_out), .level_pend(level_pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin inc = 1'b1; tick(); inc = 1'b0; tick(); end
  endtask

  task automatic pulse_dec(input int n);
    repeat (n) begin dec = 1'b1; tick(); dec = 1'b0; tick(); end
  endtask

  task automatic commit();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic send(input string tag, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [7:0] er, input logic [7:0] eg,
                      input logic [7:0] eb);
    in_valid = 1'b1; in_r = r; in_g = g; in_b = b; pass_in = {r, g, b};
    tick();
    in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; pass_in = '0;
    tick();
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".vld"},  32'(out_valid), 32'd1);
    chk({tag, ".r"},    32'(out_r), 32'(er));
    chk({tag, ".g"},    32'(out_g), 32'(eg));
    chk({tag, ".b"},    32'(out_b), 32'(eb));
    chk({tag, ".pass"}, 32'(pass_thru), 32'({r, g, b}));
  endtask

  initial begin
    rst = 1'b1; inc = 1'b0; dec = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; pass_in = '0;
    tick(); tick();
    chk("rst.lvl",  32'(level_out), 32'd8);
    chk("rst.pend", 32'(level_pend), 32'd8);
    chk("rst.vld",  32'(out_valid), 32'd0);
    chk("rst.r",    32'(out_r), 32'd0);
    chk("rst.pass", 32'(pass_thru), 32'd0);
    rst = 1'b0;
    tick();

    // T1 identity at unity level
    send("t1", 8'd200, 8'd128, 8'd50, 8'd200, 8'd128, 8'd50);
    chk("t1.lvl", 32'(level_out), 32'd8);

    // T2 pending step is not applied until frame_start
    pulse_inc(1);
    chk("t2.pend", 32'(level_pend), 32'd9);
    chk("t2.lvl",  32'(level_out), 32'd8);
    send("t2a", 8'd200, 8'd128, 8'd50, 8'd200, 8'd128, 8'd50);
    commit();
    chk("t2.commit", 32'(level_out), 32'd9);
    send("t2b", 8'd200, 8'd128, 8'd50, 8'd209, 8'd128, 8'd41);

    // T3 maximum level with clamping at both ends
    pulse_inc(6);
    commit();
    chk("t3.lvl", 32'(level_out), 32'd15);
    send("t3", 8'd255, 8'd0, 8'd127, 8'd255, 8'd0, 8'd127);
    send("t3b", 8'd100, 8'd128, 8'd140, 8'd76, 8'd128, 8'd150);

    // T4 saturation, simultaneous buttons, step coinciding with commit
    pulse_inc(10);
    chk("t4.sat_hi", 32'(level_pend), 32'd15);
    pulse_dec(20);
    chk("t4.sat_lo", 32'(level_pend), 32'd0);
    inc = 1'b1; dec = 1'b1;
    repeat (6) tick();
    inc = 1'b0; dec = 1'b0; tick();
    chk("t4.both", 32'(level_pend), 32'd0);
    commit();
    chk("t4.lvl0", 32'(level_out), 32'd0);
    send("t4.zero", 8'd200, 8'd10, 8'd255, 8'd128, 8'd128, 8'd128);
    pulse_inc(1);
    inc = 1'b1; frame_start = 1'b1; tick();
    inc = 1'b0; frame_start = 1'b0; tick();
    chk("t4.same_lvl",  32'(level_out), 32'd1);
    chk("t4.same_pend", 32'(level_pend), 32'd2);

    // T5 auto-repeat while held (REPEAT_CYC=4)
    pulse_inc(6);
    chk("t5.start", 32'(level_pend), 32'd8);
    inc = 1'b1;
    repeat (10) tick();
    inc = 1'b0; tick();
    chk("t5.rep", 32'(level_pend), 32'd11);
    commit();
    send("t5.px", 8'd200, 8'd128, 8'd50, 8'd227, 8'd128, 8'd21);

    // T6 reset flushes in-flight pixels and restores levels
    in_valid = 1'b1; in_r = 8'd10; in_g = 8'd20; in_b = 8'd30;
    tick(); tick(); tick();
    chk("t6.pre", 32'(out_valid), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6.rst_vld", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6.flush%0d", k), 32'(out_valid), 32'd0);
    end
    chk("t6.lvl",  32'(level_out), 32'd8);
    chk("t6.pend", 32'(level_pend), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
